// File: rtl/slrv_ctrl_pkg.sv
// rtl/slrv_ctrl_pkg.sv - shared encodings for the SLRV run controller
package slrv_ctrl_pkg;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_HALT       = 3'd1;
  localparam logic [2:0] OP_RUN        = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_SET_BP     = 3'd4;
  localparam logic [2:0] OP_RESET_CORE = 3'd5;
  localparam logic [2:0] OP_DEBUG      = 3'd6;
  localparam logic [2:0] OP_ILLEGAL    = 3'd7;

  localparam int STEP_W = 16;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_HALTED     = 2'd1,
    ST_RUNNING    = 2'd2,
    ST_STEPPING   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_CMD        = 2'd0,
    CAUSE_STEP_DONE  = 2'd1,
    CAUSE_BREAKPOINT = 2'd2,
    CAUSE_RESET      = 2'd3
  } cause_e;

  // A zero step count still executes one instruction.
  function automatic logic [STEP_W-1:0] step_load(input logic [STEP_W-1:0] arg);
    return (arg == '0) ? STEP_W'(1) : arg;
  endfunction

endpackage

// File: rtl/slrv_run_ctrl_if.sv
// rtl/slrv_run_ctrl_if.sv - host command port of the SLRV run controller
interface slrv_run_ctrl_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );

endinterface

// File: rtl/slrv_run_ctrl.sv
// rtl/slrv_run_ctrl.sv - reset/halt/run/step/breakpoint sequencer for the SLRV core
module slrv_run_ctrl
  import slrv_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter bit AUTO_RUN     = 1'b0,
  parameter int CNT_W        = 32
) (
  input  logic             wb_clk_i,
  input  logic             reset_n,
  slrv_run_ctrl_if.slave   cmd,
  input  logic [8:0]       pc_addr,
  output logic             core_reset,
  output logic             pc_control,
  output logic             debug,
  output logic [1:0]       state_o,
  output logic [1:0]       halt_cause,
  output logic             step_done,
  output logic             cmd_err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [STEP_W-1:0] HOLD_RELOAD = STEP_W'(RESET_CYCLES - 1);

  state_e              r_state;
  cause_e              r_cause;
  logic [STEP_W-1:0]   r_cnt;
  logic                r_core_reset;
  logic                r_debug;
  logic                r_bp_en;
  logic [8:0]          r_bp_addr;
  logic                r_skip_bp;
  logic                r_step_done;
  logic                r_cmd_err;
  logic [CNT_W-1:0]    r_retired;

  state_e              w_state_nxt;
  cause_e              w_cause_nxt;
  logic [STEP_W-1:0]   w_cnt_nxt;
  logic                w_debug_nxt;
  logic                w_bp_en_nxt;
  logic [8:0]          w_bp_addr_nxt;
  logic                w_skip_bp_nxt;
  logic                w_cmd_err_nxt;
  logic                w_clr_retired;
  logic                w_pc_control;
  logic                w_accept;
  logic                w_bp_hit;
  logic                w_halt_cmd;
  logic                w_flow_cmd;

  assign cmd.cmd_ready = (r_state != ST_RESET_HOLD);

  always_comb begin
    w_accept      = cmd.cmd_valid && cmd.cmd_ready;
    w_bp_hit      = r_bp_en && (pc_addr == r_bp_addr) && !r_skip_bp;
    w_halt_cmd    = w_accept && (cmd.cmd_op == OP_HALT);
    w_flow_cmd    = w_accept && ((cmd.cmd_op == OP_RUN) || (cmd.cmd_op == OP_STEP) ||
                                 (cmd.cmd_op == OP_RESET_CORE));
    w_state_nxt   = r_state;
    w_cause_nxt   = r_cause;
    w_cnt_nxt     = r_cnt;
    w_debug_nxt   = r_debug;
    w_bp_en_nxt   = r_bp_en;
    w_bp_addr_nxt = r_bp_addr;
    w_skip_bp_nxt = r_skip_bp;
    w_cmd_err_nxt = 1'b0;
    w_clr_retired = 1'b0;
    w_pc_control  = 1'b0;

    // Commands legal in every non-reset state.
    if (w_accept) begin
      case (cmd.cmd_op)
        OP_SET_BP: begin
          w_bp_addr_nxt = cmd.cmd_arg[8:0];
          w_bp_en_nxt   = cmd.cmd_arg[15];
        end
        OP_DEBUG:   w_debug_nxt   = cmd.cmd_arg[0];
        OP_ILLEGAL: w_cmd_err_nxt = 1'b1;
        default: ;
      endcase
    end

    case (r_state)
      ST_RESET_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = AUTO_RUN ? ST_RUNNING : ST_HALTED;
          w_cause_nxt = CAUSE_RESET;
        end else begin
          w_cnt_nxt = r_cnt - STEP_W'(1);
        end
      end

      ST_HALTED: begin
        if (w_accept) begin
          case (cmd.cmd_op)
            OP_RUN: begin
              w_state_nxt   = ST_RUNNING;
              w_skip_bp_nxt = 1'b1;
            end
            OP_STEP: begin
              w_state_nxt = ST_STEPPING;
              w_cnt_nxt   = step_load(cmd.cmd_arg);
            end
            OP_RESET_CORE: begin
              w_state_nxt   = ST_RESET_HOLD;
              w_cnt_nxt     = HOLD_RELOAD;
              w_cause_nxt   = CAUSE_RESET;
              w_clr_retired = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_RUNNING: begin
        w_pc_control  = !w_bp_hit;
        w_skip_bp_nxt = 1'b0;
        if (w_flow_cmd) begin
          w_cmd_err_nxt = 1'b1;
        end
        // Breakpoint outranks a HALT arriving in the same cycle.
        if (w_bp_hit) begin
          w_state_nxt = ST_HALTED;
          w_cause_nxt = CAUSE_BREAKPOINT;
        end else if (w_halt_cmd) begin
          w_state_nxt = ST_HALTED;
          w_cause_nxt = CAUSE_CMD;
        end
      end

      ST_STEPPING: begin
        w_pc_control = 1'b1;
        if (w_flow_cmd) begin
          w_cmd_err_nxt = 1'b1;
        end
        if (r_cnt == STEP_W'(1)) begin
          w_state_nxt = ST_HALTED;
          w_cause_nxt = CAUSE_STEP_DONE;
        end else begin
          w_cnt_nxt = r_cnt - STEP_W'(1);
          if (w_halt_cmd) begin
            w_state_nxt = ST_HALTED;
            w_cause_nxt = CAUSE_CMD;
          end
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      r_state      <= ST_RESET_HOLD;
      r_cause      <= CAUSE_RESET;
      r_cnt        <= HOLD_RELOAD;
      r_core_reset <= 1'b1;
      r_debug      <= 1'b0;
      r_bp_en      <= 1'b0;
      r_bp_addr    <= '0;
      r_skip_bp    <= 1'b0;
      r_step_done  <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cause      <= w_cause_nxt;
      r_cnt        <= w_cnt_nxt;
      r_core_reset <= (w_state_nxt == ST_RESET_HOLD);
      r_debug      <= w_debug_nxt;
      r_bp_en      <= w_bp_en_nxt;
      r_bp_addr    <= w_bp_addr_nxt;
      r_skip_bp    <= w_skip_bp_nxt;
      r_step_done  <= (w_state_nxt == ST_HALTED) && (r_state != ST_HALTED);
      r_cmd_err    <= w_cmd_err_nxt;
      if (w_clr_retired) begin
        r_retired <= '0;
      end else if (w_pc_control) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign core_reset = r_core_reset;
  assign pc_control = w_pc_control;
  assign debug      = r_debug;
  assign state_o    = r_state;
  assign halt_cause = r_cause;
  assign step_done  = r_step_done;
  assign cmd_err    = r_cmd_err;
  assign retired    = r_retired;

endmodule

// File: tb/tb_slrv_run_ctrl.sv
// tb/tb_slrv_run_ctrl.sv - vector table and scoreboard bench for slrv_run_ctrl
module tb_slrv_run_ctrl;
  import slrv_ctrl_pkg::*;

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic [15:0] arg;
    logic [8:0]  pc;
    logic        exp_pc;
    logic [1:0]  exp_state;
    logic [1:0]  exp_cause;
    logic        exp_sd;
    logic        exp_err;
    logic        exp_dbg;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic        wb_clk_i = 1'b0;
  logic        reset_n  = 1'b0;
  logic [8:0]  pc_addr  = '0;
  logic        core_reset;
  logic        pc_control;
  logic        debug;
  logic [1:0]  state_o;
  logic [1:0]  halt_cause;
  logic        step_done;
  logic        cmd_err;
  logic [31:0] retired;

  slrv_run_ctrl_if cmd_if ();

  slrv_run_ctrl #(
    .RESET_CYCLES(4),
    .AUTO_RUN    (1'b0),
    .CNT_W       (32)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .reset_n   (reset_n),
    .cmd       (cmd_if),
    .pc_addr   (pc_addr),
    .core_reset(core_reset),
    .pc_control(pc_control),
    .debug     (debug),
    .state_o   (state_o),
    .halt_cause(halt_cause),
    .step_done (step_done),
    .cmd_err   (cmd_err),
    .retired   (retired)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input int idx, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %0h, expected %0h", idx, name, act, exp);
    end
  endtask

  task automatic add(input int rst, input int op, input int arg, input int pc,
                     input int epc, input int est, input int ec, input int esd,
                     input int eerr, input int edbg, input int eret);
    vec_t v;
    v.rst       = 1'(rst);
    v.op        = 3'(op);
    v.arg       = 16'(arg);
    v.pc        = 9'(pc);
    v.exp_pc    = 1'(epc);
    v.exp_state = 2'(est);
    v.exp_cause = 2'(ec);
    v.exp_sd    = 1'(esd);
    v.exp_err   = 1'(eerr);
    v.exp_dbg   = 1'(edbg);
    v.exp_ret   = 32'(eret);
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_arg   = 16'd0;

    // rst op arg pc | pc_ctl state cause step_done err dbg retired
    add(0, 3, 5, 0,     0, 3, 3, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      add(0, 0, 0, 0,   1, (k < 5) ? 3 : 1, (k < 5) ? 3 : 1, (k == 5) ? 1 : 0, 0, 0, k);
    add(0, 0, 0, 0,     0, 1, 1, 0, 0, 0, 5);
    add(0, 3, 0, 0,     0, 3, 1, 0, 0, 0, 5);
    add(0, 0, 0, 0,     1, 1, 1, 1, 0, 0, 6);
    add(0, 6, 1, 0,     0, 1, 1, 0, 0, 1, 6);
    add(0, 4, 'h8010, 0, 0, 1, 1, 0, 0, 1, 6);
    add(0, 2, 0, 'h0C,  0, 2, 1, 0, 0, 1, 6);
    for (int k = 0; k < 4; k++)
      add(0, 0, 0, 'h0C + k, 1, 2, 1, 0, 0, 1, 7 + k);
    add(0, 0, 0, 'h10,  0, 1, 2, 1, 0, 1, 10);
    add(0, 2, 0, 'h10,  0, 2, 2, 0, 0, 1, 10);
    add(0, 0, 0, 'h10,  1, 2, 2, 0, 0, 1, 11);
    add(0, 0, 0, 'h11,  1, 2, 2, 0, 0, 1, 12);
    add(0, 3, 3, 'h12,  1, 2, 2, 0, 1, 1, 13);
    add(0, 1, 0, 'h13,  1, 1, 0, 1, 0, 1, 14);
    add(0, 7, 0, 0,     0, 1, 0, 0, 1, 1, 14);
    add(0, 1, 0, 0,     0, 1, 0, 0, 0, 1, 14);
    add(0, 2, 0, 'h20,  0, 2, 0, 0, 0, 1, 14);
    for (int k = 1; k <= 7; k++)
      add(0, 0, 0, 'h20, 1, 2, 0, 0, 0, 1, 14 + k);
    add(0, 1, 0, 'h20,  1, 1, 0, 1, 0, 1, 22);
    add(0, 2, 0, 'h20,  0, 2, 0, 0, 0, 1, 22);
    add(0, 0, 0, 'h20,  1, 2, 0, 0, 0, 1, 23);
    add(0, 1, 0, 'h10,  0, 1, 2, 1, 0, 1, 23);
    add(0, 3, 10, 0,    0, 3, 2, 0, 0, 1, 23);
    add(0, 0, 0, 0,     1, 3, 2, 0, 0, 1, 24);
    add(0, 2, 0, 0,     1, 3, 2, 0, 1, 1, 25);
    add(0, 1, 0, 0,     1, 1, 0, 1, 0, 1, 26);
    add(0, 5, 0, 0,     0, 0, 3, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++)
      add(0, 0, 0, 0,   0, (k < 4) ? 0 : 1, 3, (k == 4) ? 1 : 0, 0, 1, 0);
    add(0, 2, 0, 'h0F,  0, 2, 3, 0, 0, 1, 0);
    add(0, 0, 0, 'h0F,  1, 2, 3, 0, 0, 1, 1);
    add(0, 0, 0, 'h10,  0, 1, 2, 1, 0, 1, 1);
    add(0, 3, 100, 0,   0, 3, 2, 0, 0, 1, 1);
    add(0, 0, 0, 0,     1, 3, 2, 0, 0, 1, 2);
    add(1, 0, 0, 0,     1, 0, 3, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      add(0, 0, 0, 0,   0, (k < 4) ? 0 : 1, 3, (k == 4) ? 1 : 0, 0, 0, 0);
    add(0, 2, 0, 'h10,  0, 2, 3, 0, 0, 0, 0);
    add(0, 0, 0, 'h10,  1, 2, 3, 0, 0, 0, 1);
    add(0, 0, 0, 'h10,  1, 2, 3, 0, 0, 0, 2);
    add(0, 1, 0, 'h10,  1, 1, 0, 1, 0, 0, 3);

    // Power-on reset: four hold cycles, then HALTED with a single step_done pulse.
    reset_n = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk_i);
      chk(-1, "hold core_reset", 32'(core_reset), 32'd1);
      chk(-1, "hold cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
      chk(-1, "hold step_done", 32'(step_done), 32'd0);
    end
    @(negedge wb_clk_i);
    chk(-1, "por core_reset", 32'(core_reset), 32'd0);
    chk(-1, "por state", 32'(state_o), 32'd1);
    chk(-1, "por halt_cause", 32'(halt_cause), 32'd3);
    chk(-1, "por step_done", 32'(step_done), 32'd1);
    chk(-1, "por pc_control", 32'(pc_control), 32'd0);
    chk(-1, "por retired", retired, 32'd0);
    chk(-1, "por cmd_err", 32'(cmd_err), 32'd0);
    @(negedge wb_clk_i);
    chk(-1, "por step_done pulse end", 32'(step_done), 32'd0);
    @(posedge wb_clk_i);
    #1;

    foreach (vecs[i]) begin
      reset_n          = !vecs[i].rst;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = vecs[i].op;
      cmd_if.cmd_arg   = vecs[i].arg;
      pc_addr          = vecs[i].pc;
      @(negedge wb_clk_i);
      chk(i, "pc_control", 32'(pc_control), 32'(vecs[i].exp_pc));
      sb.push_back(vecs[i]);
      @(posedge wb_clk_i);
      #1;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL v%0d scoreboard: got empty queue, expected an entry", i);
      end else begin
        e = sb.pop_front();
        chk(i, "state", 32'(state_o), 32'(e.exp_state));
        chk(i, "core_reset", 32'(core_reset), 32'(e.exp_state == 2'd0));
        chk(i, "cmd_ready", 32'(cmd_if.cmd_ready), 32'(e.exp_state != 2'd0));
        if (e.exp_state != 2'd0 || e.rst)
          chk(i, "halt_cause", 32'(halt_cause), 32'(e.exp_cause));
        chk(i, "step_done", 32'(step_done), 32'(e.exp_sd));
        chk(i, "cmd_err", 32'(cmd_err), 32'(e.exp_err));
        chk(i, "debug", 32'(debug), 32'(e.exp_dbg));
        chk(i, "retired", retired, e.exp_ret);
      end
    end

    cmd_if.cmd_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/slrv_run_ctrl.md
Name: slrv_run_ctrl

Overview:
Execution controller for the SLRV core. It owns the core's reset and `pc_control` (PC advance enable) and its `debug` select. It sequences the core through reset-hold, halt, free-run, N-instruction single-step and word-address breakpoint stop. Host commands arrive on a valid/ready port driven from the logic analyzer or wishbone glue in the user-project wrapper.

Parameters:
- RESET_CYCLES, 4: number of cycles core_reset is held after controller reset or a RESET_CORE command; minimum 1.
- AUTO_RUN, 0: if 1, enter RUNNING instead of HALTED when the reset hold ends.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- wb_clk_i, input, 1: clock, the core clock.
- reset_n, input, 1: synchronous active-low reset.
- cmd_valid, input, 1: command strobe.
- cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
- cmd_op, input, 3: 0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 SET_BP, 5 RESET_CORE, 6 DEBUG.
- cmd_arg, input, 16: command argument.
- pc_addr, input, 9: core insMemAddr (word address of the current instruction).
- core_reset, output, 1: active-high reset to the core.
- pc_control, output, 1: core PC advance enable.
- debug, output, 1: core debug select.
- state_o, output, 2: current state (encoding below).
- halt_cause, output, 2: 0 CMD, 1 STEP_DONE, 2 BREAKPOINT, 3 RESET.
- step_done, output, 1: one-cycle pulse on every entry to HALTED.
- cmd_err, output, 1: one-cycle pulse when an accepted command is illegal in the current state.
- retired, output, CNT_W: count of cycles with pc_control=1; wraps.

Behaviour:
- States: RESET_HOLD=0, HALTED=1, RUNNING=2, STEPPING=3.
- reset_n=0, sampled at the clock edge, sets:
  - state RESET_HOLD, hold counter = RESET_CYCLES-1;
  - core_reset=1, pc_control=0, debug=0;
  - bp_en=0, bp_addr=0, retired=0;
  - halt_cause=RESET, step_done=0, cmd_err=0.
  - Reset asserted mid-run or mid-step aborts immediately, with no step_done pulse.
- RESET_HOLD:
  - core_reset=1, cmd_ready=0.
  - Counter decrements each cycle; at 0 go to HALTED (pulse step_done, cause RESET), or to RUNNING if AUTO_RUN=1.
- core_reset is a registered output: 1 exactly in RESET_HOLD, 0 otherwise.
- cmd_ready=1 in HALTED, RUNNING and STEPPING. Each command takes one cycle; its effect is visible from the next cycle.
- HALTED:
  - RUN: go to RUNNING; set skip_bp=1.
  - STEP: load step_cnt = (arg==0 ? 1 : arg); go to STEPPING.
  - RESET_CORE: go to RESET_HOLD, reload the counter, clear retired; debug and breakpoint registers are kept.
  - HALT and NOP: no effect.
- SET_BP (any non-reset state): bp_addr=arg[8:0], bp_en=arg[15].
- DEBUG (any non-reset state): debug=arg[0].
- RUNNING:
  - pc_control = !(bp_en && pc_addr==bp_addr && !skip_bp), combinational.
  - skip_bp clears after the first RUNNING cycle, so a resume from a breakpoint executes that instruction.
  - Breakpoint hit: pc_control=0 that cycle; next state HALTED, cause BREAKPOINT, step_done pulse.
  - HALT: next state HALTED, cause CMD, step_done pulse. pc_control is still 1 in the accept cycle.
  - RUN, STEP, RESET_CORE: accepted, no effect, cmd_err pulse.
- STEPPING:
  - pc_control=1 every cycle; breakpoints are ignored.
  - step_cnt decrements each cycle. In the cycle step_cnt==1, go to HALTED with cause STEP_DONE and a step_done pulse. Exactly step_cnt instructions retire.
  - HALT aborts: the accept cycle still retires, then HALTED with cause CMD.
  - RUN, STEP, RESET_CORE: cmd_err pulse, no effect.
- Simultaneous HALT and breakpoint hit in RUNNING: cause BREAKPOINT (it has priority), and pc_control=0.
- retired increments when pc_control=1; it wraps at 2^CNT_W.
- Illegal cmd_op 7: accepted, cmd_err pulse, no effect.
- cmd_err and step_done are never asserted together with core_reset=1.

Decomposition:
- Shared package slrv_ctrl_pkg holds:
  - command opcode constants;
  - state encoding and halt_cause encoding (2-bit each).
- A single module is sufficient. The down-counter shared by the RESET_HOLD hold count and step_cnt is kept inline; no sub-module.

Test Plan:
- Reset with RESET_CYCLES=4, AUTO_RUN=0: expect:
  - core_reset=1 for 4 cycles after reset_n rises;
  - then state=HALTED, halt_cause=3, one step_done pulse;
  - pc_control=0, retired=0.
- STEP with arg=5 from HALTED: expect:
  - pc_control=1 for exactly 5 cycles, retired=5;
  - then HALTED, halt_cause=1, step_done pulse in the 6th cycle.
- SET_BP arg=0x8010 (enable, word addr 0x10), then RUN with pc_addr ramping by 1 from 0x0C:
  - pc_control=0 in the cycle pc_addr=0x10, then HALTED with cause=2.
  - A second RUN: pc_control=1 in the first cycle at 0x10, and the core advances.
- RUN then HALT after 7 cycles:
  - retired=8 (accept cycle included), cause=0.
  - A STEP issued while RUNNING: cmd_err pulse, state unchanged.
- reset_n=0 mid STEPPING (arg=100) → RESET_HOLD next cycle:
  - no step_done, retired=0, bp_en=0.
- DEBUG arg=1 in HALTED → debug=1 next cycle; RESET_CORE → debug stays 1, retired cleared, 4 hold cycles.
